// File: rtl/serial_addsub_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_addsub_pkg
//  Description : Shared types and constants for the bit-serial add/subtract
//                unit (FSM state encoding and operation-select values).
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_addsub_pkg;

    // Three-state controller: waiting, shifting bits, result presented.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Operation select carried on the mode input.
    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage
`default_nettype wire

// File: rtl/serial_addsub_if.sv
`default_nettype none
// ============================================================================
//  Module      : serial_addsub_if
//  Description : Request/result bundle for serial_addsub. The master issues
//                operations, the slave (the arithmetic unit) returns results.
//  Revision    : 1.0 - initial release
// ============================================================================
interface serial_addsub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             overflow;

    modport master (
        output start, mode, a, b,
        input  busy, done, sum, carry_out, overflow
    );

    modport slave (
        input  start, mode, a, b,
        output busy, done, sum, carry_out, overflow
    );
endinterface
`default_nettype wire

// File: rtl/serial_addsub_fa_cell.sv
`default_nettype none
// ============================================================================
//  Module      : fa_cell
//  Description : Combinational 1-bit full adder; the only arithmetic element
//                of the serial datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
module fa_cell (
    input  wire logic a,
    input  wire logic b,
    input  wire logic cin,
    output logic      s,
    output logic      cout
);
    // Sum and majority carry.
    always_comb begin
        s    = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
    end
endmodule
`default_nettype wire

// File: rtl/serial_addsub.sv
`default_nettype none
// ============================================================================
//  Module      : serial_addsub
//  Description : Bit-serial two's-complement adder/subtractor. One bit per
//                clock, LSB first, through a single full-adder cell. Results
//                (sum, carry_out, overflow) are registered on entry to DONE.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    serial_addsub_if.slave bus
);
    import serial_addsub_pkg::*;

    localparam int              CNT_W  = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    // Holds the low WIDTH-1 result bits; the MSB comes straight from the
    // adder in the final RUN cycle.
    logic [WIDTH-2:0]   r_res;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_carry;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_ovf;

    logic               w_s;
    logic               w_cout;
    logic               w_last;
    logic               w_start_ok;
    logic [WIDTH-1:0]   w_res_full;

    // Start is honoured only outside RUN, so a request in flight is never disturbed.
    assign w_start_ok = bus.start && (r_state != RUN);
    assign w_last     = (r_state == RUN) && (r_cnt == C_LAST);
    assign w_res_full = {w_s, r_res};

    fa_cell u_fa (
        .a    (r_a[0]),
        .b    (r_b[0]),
        .cin  (r_carry),
        .s    (w_s),
        .cout (w_cout)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: RUN for WIDTH cycles, DONE for one, chaining on start.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_state_next = RUN;
            RUN:     if (w_last)    w_state_next = DONE;
            DONE:    w_state_next = bus.start ? RUN : IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Operand capture and bit-serial shifting; subtract uses a + ~b + 1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
        end else if (w_start_ok) begin
            r_a     <= bus.a;
            r_b     <= (bus.mode == MODE_SUB) ? ~bus.b : bus.b;
            r_res   <= '0;
            r_cnt   <= '0;
            r_carry <= bus.mode;
        end else if (r_state == RUN) begin
            r_a     <= r_a >> 1;
            r_b     <= r_b >> 1;
            r_res   <= w_res_full[WIDTH-1:1];
            r_cnt   <= r_cnt + CNT_W'(1);
            r_carry <= w_cout;
        end
    end

    // Result registers update only on the last RUN cycle; overflow compares
    // carry into the MSB (r_carry) with carry out of it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (w_last) begin
            r_sum  <= w_res_full;
            r_cout <= w_cout;
            r_ovf  <= r_carry ^ w_cout;
        end
    end

    assign bus.busy      = (r_state == RUN);
    assign bus.done      = (r_state == DONE);
    assign bus.sum       = r_sum;
    assign bus.carry_out = r_cout;
    assign bus.overflow  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_serial_addsub.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_addsub
//  Description : Scoreboard bench for serial_addsub (WIDTH=8) with directed
//                vectors and hand-computed results.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_addsub;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    serial_addsub_if #(.WIDTH(WIDTH)) bus ();

    serial_addsub #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
        int         cyc;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   nchk = 0;
    int   nfail = 0;
    int   cyc = 0;
    int   busy_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        nchk++;
        if (act !== req) begin
            nfail++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            if (q.size() == 0) begin
                nchk++;
                nfail++;
                $display("FAIL unexpected_done: actual done=1 required no pulse (cycle %0d)", cyc);
            end else begin
                e = q.pop_front();
                check("sum",       {24'd0, bus.sum},     {24'd0, e.sum});
                check("carry_out", {31'd0, bus.carry_out}, {31'd0, e.cout});
                check("overflow",  {31'd0, bus.overflow},  {31'd0, e.ovf});
                check("latency",   cyc,                    e.cyc);
                check("busy_len",  busy_cnt,               8);
            end
            busy_cnt = 0;
        end else if (bus.busy === 1'b1) begin
            busy_cnt++;
        end else begin
            busy_cnt = 0;
        end
    end

    // Drive a start for one cycle at a negedge and record the expectation.
    task automatic issue(input logic m, input logic [7:0] x, input logic [7:0] y,
                         input logic [7:0] es, input logic ec, input logic eo);
        exp_t t;
        bus.start = 1'b1;
        bus.mode  = m;
        bus.a     = x;
        bus.b     = y;
        t.sum  = es;
        t.cout = ec;
        t.ovf  = eo;
        t.cyc  = cyc + 9;
        q.push_back(t);
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = 8'($urandom);
        bus.b     = 8'($urandom);
        bus.mode  = 1'($urandom);
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while (bus.done !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (n >= 30) begin
            nchk++;
            nfail++;
            $display("FAIL timeout_%s: actual no done required done within 30 cycles", nm);
        end
    endtask

    task automatic op(input logic m, input logic [7:0] x, input logic [7:0] y,
                      input logic [7:0] es, input logic ec, input logic eo, input string nm);
        issue(m, x, y, es, ec, eo);
        wait_done(nm);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual simulation still running required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0;
        bus.mode  = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        rst_n     = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, bus.busy},      0);
        check("rst_done", {31'd0, bus.done},      0);
        check("rst_sum",  {24'd0, bus.sum},       0);
        check("rst_cout", {31'd0, bus.carry_out}, 0);
        check("rst_ovf",  {31'd0, bus.overflow},  0);
        rst_n = 1'b1;
        @(negedge clk);

        op(1'b0, 8'd100, 8'd27, 8'd127, 1'b0, 1'b0, "add_100_27");
        repeat (3) @(negedge clk);
        check("hold_sum",  {24'd0, bus.sum},  127);
        check("hold_done", {31'd0, bus.done}, 0);
        check("idle_busy", {31'd0, bus.busy}, 0);

        op(1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, "add_127_1");
        op(1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, "add_ff_1");
        op(1'b1, 8'd5,  8'd7,  8'hFE, 1'b0, 1'b0, "sub_5_7");
        op(1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, "sub_80_1");
        op(1'b1, 8'd7,  8'd7,  8'h00, 1'b1, 1'b0, "sub_7_7");

        // Start re-pulsed in RUN cycle 3 must be ignored.
        issue(1'b0, 8'd100, 8'd27, 8'd127, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        bus.start = 1'b1;
        bus.mode  = 1'b1;
        bus.a     = 8'h55;
        bus.b     = 8'h11;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done("restart_ignored");
        repeat (12) @(negedge clk);

        // Reset in RUN cycle 4 aborts; start during reset is ignored.
        bus.start = 1'b1;
        bus.mode  = 1'b0;
        bus.a     = 8'd9;
        bus.b     = 8'd9;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n     = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        check("abort_busy", {31'd0, bus.busy},      0);
        check("abort_done", {31'd0, bus.done},      0);
        check("abort_sum",  {24'd0, bus.sum},       0);
        check("abort_cout", {31'd0, bus.carry_out}, 0);
        check("abort_ovf",  {31'd0, bus.overflow},  0);
        rst_n     = 1'b1;
        bus.start = 1'b0;
        @(negedge clk);
        check("rst_start_ignored", {31'd0, bus.busy}, 0);
        repeat (12) @(negedge clk);
        op(1'b0, 8'd1, 8'd1, 8'd2, 1'b0, 1'b0, "add_1_1");

        // Back-to-back: start held in the DONE cycle.
        issue(1'b0, 8'h40, 8'h40, 8'h80, 1'b0, 1'b1);
        wait_done("b2b_first");
        issue(1'b0, 8'd3, 8'd4, 8'd7, 1'b0, 1'b0);
        wait_done("b2b_second");
        repeat (5) @(negedge clk);

        check("queue_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/serial_addsub.md
SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width in bits; SHALL be legal for WIDTH >= 2.
REQ-002 Clocking SHALL be one clock with a synchronous, active-low reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  synchronous active-low reset, sampled on the clk rising edge.
REQ-005 start  input  1  request a new operation; sampled only when the block is idle or done.
REQ-006 mode  input  1  operation select: 0 = a+b, 1 = a-b; captured with start.
REQ-007 a  input  WIDTH  first operand; captured with start.
REQ-008 b  input  WIDTH  second operand; captured with start.
REQ-009 busy  output  1  high while an operation is in progress.
REQ-010 done  output  1  single-cycle pulse: result outputs have just been updated.
REQ-011 sum  output  WIDTH  result, two's-complement wrap.
REQ-012 carry_out  output  1  final carry; in subtract mode, 1 = no borrow.
REQ-013 overflow  output  1  signed overflow of the last result.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-015 In IDLE or DONE, start=1 SHALL capture a, b and mode, clear the bit counter, preset the carry register to mode, and enter RUN.
REQ-016 In subtract mode the captured b SHALL be bitwise inverted, so that a-b = a + ~b + 1.
REQ-017 In RUN, each cycle SHALL process exactly one bit, LSB first, through a single 1-bit full-adder cell: the sum bit shifts into the internal result register and the carry register updates.
REQ-018 RUN SHALL last exactly WIDTH cycles, then transition to DONE; DONE SHALL last one cycle, then go to IDLE unless start=1.
REQ-019 Latency: done SHALL be high exactly WIDTH+1 cycles after the edge that samples start; done is high only in DONE.
REQ-020 busy SHALL be high in RUN only; start while busy=1 SHALL be ignored, with no effect on the operation in flight.
REQ-021 sum, carry_out and overflow SHALL update only on entry to DONE and SHALL hold until the next DONE entry.
REQ-022 overflow SHALL equal the carry into the MSB XOR the carry out of the MSB.
REQ-023 start asserted in the DONE cycle SHALL begin the next operation with no IDLE gap (back-to-back); done still pulses for the completed operation.
REQ-024 Input changes on a and b after capture SHALL have no effect on the current result.

Reset
REQ-025 rst_n=0 SHALL, on the clk edge, force IDLE and clear busy, done, sum, carry_out, overflow, the counter, the carry register and the operand registers to 0.
REQ-026 Reset in RUN or DONE SHALL abort the operation; no done pulse SHALL follow, and outputs SHALL read 0.
REQ-027 start sampled in the same cycle as rst_n=0 SHALL be ignored.

Structure
REQ-028 Package serial_addsub_pkg SHALL hold the FSM state typedef (IDLE/RUN/DONE) and the MODE_ADD=0 and MODE_SUB=1 constants.
REQ-029 The bit-counter width SHALL be $clog2(WIDTH)+1, derived locally.
REQ-030 Sub-module fa_cell SHALL be a combinational 1-bit full adder (inputs a, b, cin; outputs s, cout), instantiated exactly once.

Verification (WIDTH=8)
REQ-031 add 100+27 -> sum=127, carry_out=0, overflow=0, done 9 cycles after the start edge, busy high for 8 cycles.
REQ-032 add 127+1 -> sum=0x80, carry_out=0, overflow=1; add 0xFF+0x01 -> sum=0x00, carry_out=1, overflow=0.
REQ-033 sub 5-7 -> sum=0xFE, carry_out=0, overflow=0; sub 0x80-0x01 -> sum=0x7F, carry_out=1, overflow=1.
REQ-034 start re-pulsed with new operands in RUN cycle 3 -> ignored; original result is reported and only one done pulse occurs.
REQ-035 rst_n=0 in RUN cycle 4 -> IDLE next cycle, all outputs 0, no done pulse; a following add 1+1 -> sum=2.
REQ-036 start held high in the DONE cycle with 3+4 -> first result reported, then sum=7 exactly 9 cycles later.
